// File: rtl/motor_seq_pkg.sv
// Shared types, default timing constants and helpers for the motor start sequencer.
// Pure declarations: no latency or flow control of its own.
package motor_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PULSE,
    S0,
    S1,
    S10,
    GWAIT,
    RUN,
    COOL,
    FAULT
  } state_t;

  localparam int DEF_Y_WIN     = 2;
  localparam int DEF_X_WIN     = 16;
  localparam int DEF_COOL_CYC  = 4;
  localparam int DEF_MAX_RETRY = 3;

  // Widest window minus one must fit; the counter saturates at all-ones.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic is_search(input state_t s);
    return (s == S0) || (s == S1) || (s == S10);
  endfunction

endpackage

// File: rtl/motor_seq_timer.sv
// Loadable, clearable saturating up-counter with terminal-count compare; tc is combinational from cnt.
// One-cycle update latency; no flow control, counts whenever inc is high.
module motor_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/motor_start_sequencer.sv
// Retrying motor start controller: f pulse, 1-0-1 search on x, g while waiting for y, cooldown/retry, fault.
// Outputs are registered decodes of the next state (one-cycle latency from inputs); no backpressure.
module motor_start_sequencer
  import motor_seq_pkg::*;
#(
  parameter int  Y_WIN     = DEF_Y_WIN,
  parameter int  X_WIN     = DEF_X_WIN,
  parameter int  COOL_CYC  = DEF_COOL_CYC,
  parameter int  MAX_RETRY = DEF_MAX_RETRY,
  localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_req,
  input  logic          stop_req,
  input  logic          fault_clr,
  input  logic          x,
  input  logic          y,
  output logic          f,
  output logic          g,
  output logic          running,
  output logic          fault,
  output logic [RW-1:0] retry_cnt
);

  localparam int TW = tmr_width(X_WIN, Y_WIN, COOL_CYC);

  state_t        state;
  state_t        nxt;
  logic [RW-1:0] retry_nxt;
  logic [TW-1:0] tc_val;
  logic          tmr_tc;
  logic          tmr_clr;
  logic          fail;

  always_comb begin
    tc_val = '0;
    case (state)
      S0, S1, S10: tc_val = TW'(X_WIN - 1);
      GWAIT:       tc_val = TW'(Y_WIN - 1);
      COOL:        tc_val = TW'(COOL_CYC - 1);
      default:     tc_val = '0;
    endcase
  end

  always_comb begin
    nxt       = state;
    retry_nxt = retry_cnt;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          nxt       = PULSE;
          retry_nxt = '0;
        end
      end
      PULSE: nxt = S0;
      S0: begin
        if (tmr_tc) fail = 1'b1;
        else        nxt  = x ? S1 : S0;
      end
      S1: begin
        if (tmr_tc) fail = 1'b1;
        else        nxt  = x ? S1 : S10;
      end
      // A match on the last window cycle wins over the timeout.
      S10: begin
        if (x)           nxt  = GWAIT;
        else if (tmr_tc) fail = 1'b1;
        else             nxt  = S0;
      end
      GWAIT: begin
        if (y)           nxt  = RUN;
        else if (tmr_tc) fail = 1'b1;
      end
      RUN:  nxt = RUN;
      COOL: begin
        if (tmr_tc) nxt = PULSE;
      end
      FAULT: begin
        if (fault_clr) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    if (fail) begin
      if (retry_cnt == RW'(MAX_RETRY)) begin
        nxt = FAULT;
      end else begin
        nxt       = COOL;
        retry_nxt = retry_cnt + 1'b1;
      end
    end

    if (stop_req && (state != IDLE) && (state != FAULT)) begin
      nxt       = IDLE;
      retry_nxt = retry_cnt;
    end
  end

  // The search states share one window, so moving between them keeps the timer running.
  assign tmr_clr = (nxt != state) && !(is_search(nxt) && is_search(state));

  motor_seq_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .inc     (1'b1),
    .load    (1'b0),
    .load_val({TW{1'b0}}),
    .tc_val  (tc_val),
    .tc      (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      retry_cnt <= '0;
      f         <= 1'b0;
      g         <= 1'b0;
      running   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nxt;
      retry_cnt <= retry_nxt;
      f         <= (nxt == PULSE);
      g         <= (nxt == GWAIT) || (nxt == RUN);
      running   <= (nxt == RUN);
      fault     <= (nxt == FAULT);
    end
  end

endmodule
